// File: rtl/logs_pkg.sv
// Shared definitions for the voice allocator: FSM state encoding and default widths.
package logs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int DEF_PW = 12;
  localparam int DEF_NW = 7;
  localparam int DEF_AW = 4;

endpackage

// File: rtl/logs_voice_alloc.sv
// Voice allocator: assigns note-on/off requests to N square-wave voices,
// scanning one voice per cycle and stealing the oldest voice when all are busy.
module logs_voice_alloc
  import logs_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = DEF_PW,
  parameter int NW = DEF_NW,
  parameter int AW = DEF_AW,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_on,
  input  logic [NW-1:0]   req_note,
  input  logic [PW-1:0]   req_period,
  output logic [N-1:0]    voice_en,
  output logic [N*PW-1:0] voice_period,
  output logic            done_valid,
  output logic            done_hit,
  output logic            done_stole,
  output logic [IW-1:0]   done_voice
);

  localparam logic [AW-1:0] AGE_MAX = '1;
  localparam logic [IW-1:0] LAST    = IW'(N - 1);

  state_e state, state_nxt;

  logic [IW-1:0] idx;
  logic          lat_on;
  logic [NW-1:0] lat_note;
  logic [PW-1:0] lat_period;

  // Scan candidates: first free voice, oldest active voice, first matching voice.
  logic          free_vld, old_vld, hit_vld;
  logic [IW-1:0] free_idx, old_idx, hit_idx;
  logic [AW-1:0] old_age;

  logic [N-1:0]         en;
  logic [N-1:0][PW-1:0] period;
  logic [N-1:0][NW-1:0] note;
  logic [N-1:0][AW-1:0] age;

  logic          accept, commit, tgt_vld;
  logic [IW-1:0] tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_SCAN;
      end
      ST_SCAN:   if (idx == LAST) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign commit = (state == ST_COMMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      lat_on     <= 1'b0;
      lat_note   <= '0;
      lat_period <= '0;
      free_vld   <= 1'b0;
      old_vld    <= 1'b0;
      hit_vld    <= 1'b0;
      free_idx   <= '0;
      old_idx    <= '0;
      hit_idx    <= '0;
      old_age    <= '0;
    end else if (accept) begin
      idx        <= '0;
      lat_on     <= req_on;
      lat_note   <= req_note;
      lat_period <= req_period;
      free_vld   <= 1'b0;
      old_vld    <= 1'b0;
      hit_vld    <= 1'b0;
      free_idx   <= '0;
      old_idx    <= '0;
      hit_idx    <= '0;
      old_age    <= '0;
    end else if (state == ST_SCAN) begin
      idx <= (idx == LAST) ? '0 : idx + 1'b1;
      if (!en[idx]) begin
        if (!free_vld) begin
          free_vld <= 1'b1;
          free_idx <= idx;
        end
      end else begin
        // strict compare keeps the lowest index on an age tie
        if (!old_vld || age[idx] > old_age) begin
          old_vld <= 1'b1;
          old_idx <= idx;
          old_age <= age[idx];
        end
        if (!hit_vld && note[idx] == lat_note) begin
          hit_vld <= 1'b1;
          hit_idx <= idx;
        end
      end
    end
  end

  // With no free voice every voice is active, so old_idx is always valid there.
  assign tgt     = lat_on ? (free_vld ? free_idx : old_idx) : hit_idx;
  assign tgt_vld = lat_on || hit_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en     <= '0;
      period <= '0;
      note   <= '0;
      age    <= '0;
    end else if (commit) begin
      for (int i = 0; i < N; i++) begin
        if (tgt_vld && tgt == IW'(i)) begin
          age[i] <= '0;
          if (lat_on) begin
            en[i]     <= 1'b1;
            note[i]   <= lat_note;
            period[i] <= lat_period;
          end else begin
            en[i]     <= 1'b0;
            period[i] <= '0;
          end
        end else if (lat_on && en[i] && age[i] != AGE_MAX) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_valid <= 1'b0;
      done_hit   <= 1'b0;
      done_stole <= 1'b0;
      done_voice <= '0;
    end else begin
      done_valid <= commit;
      if (commit) begin
        done_hit   <= tgt_vld;
        done_stole <= lat_on && !free_vld;
        done_voice <= tgt_vld ? tgt : '0;
      end
    end
  end

  assign voice_en     = en;
  assign voice_period = period;

endmodule

// File: doc/logs_voice_alloc.md
Name: logs_voice_alloc

Overview:
- Voice allocator and scheduler for the popcount/PWM mixer.
- Accepts note-on and note-off requests over a valid/ready handshake and assigns each note to one of N square-wave voices.
- Drives per-voice enable and period outputs. Each voice oscillator's 1-bit output feeds one mixer audio line.
- When all voices are busy, a note-on steals the oldest voice.

Parameters:
- N, 4, number of voices; must be at least 1.
- PW, 12, width of the period field per voice.
- NW, 7, width of the note identifier.
- AW, 4, width of the per-voice age counter; saturates at 2^AW-1.
- IW, $clog2(N) but at least 1, voice index width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  allocator can accept a request
- req_on  in  1  1 = note-on, 0 = note-off
- req_note  in  NW  note identifier
- req_period  in  PW  oscillator period for note-on; ignored for note-off
- voice_en  out  N  per-voice active flag
- voice_period  out  N*PW  packed periods; voice i occupies bits [i*PW +: PW]
- done_valid  out  1  one-cycle pulse when a request completes
- done_hit  out  1  with done_valid: 1 = a voice was assigned or released; 0 = note-off matched no voice
- done_stole  out  1  with done_valid: 1 = note-on evicted an active voice
- done_voice  out  IW  with done_valid: index of the affected voice

Behaviour:
- Reset (rst_n low, asynchronous):
  - All voice_en, voice_period, ages and note registers clear to 0.
  - FSM goes to IDLE.
  - done_* clear to 0; req_ready = 1 after reset releases.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch req_on/req_note/req_period, clear candidate registers, set scan index to 0, go to SCAN.
- SCAN:
  - req_ready = 0. Examines voice[idx] in one cycle per voice, for exactly N cycles.
  - Note-on tracking:
    - Lowest-index free voice (voice_en = 0).
    - Otherwise, the active voice with the strictly greatest age; ties go to the lowest index.
  - Note-off tracking: lowest-index active voice whose stored note equals the latched note.
  - After idx = N-1, go to COMMIT.
- COMMIT (one cycle), then return to IDLE. done_valid pulses the cycle after COMMIT, i.e. in the first IDLE cycle.
  - Note-on:
    - Every other active voice's age increments, saturating at 2^AW-1.
    - Target voice: en = 1, age = 0, note and period loaded.
    - done_hit = 1; done_stole = 1 only if no free voice existed.
  - Note-off with a match: en = 0, period cleared to 0, age = 0, done_hit = 1.
  - Note-off without a match: no state change, done_hit = 0, done_voice = 0.
- Latency:
  - Acceptance to done_valid is N+2 cycles.
  - Throughput is one request per N+2 cycles.
  - A new request may be accepted in the same cycle done_valid is high.
- Duplicate note-on for a note already sounding allocates a second voice; no deduplication.
- Outputs are registered and change only on COMMIT, so voice_period is stable while voice_en = 1.
- Asserting rst_n low mid-SCAN aborts the request with no done pulse; the request is lost.
- req_* are sampled only at acceptance; changes during SCAN are ignored.

Decomposition:
- Shared package logs_pkg:
  - FSM state encoding (ST_IDLE, ST_SCAN, ST_COMMIT).
  - Default widths (PW, NW, AW).
- No sub-module is needed inside the allocator. Oscillators and the mixer are instantiated by the parent.

Test Plan:
1. Reset, then note-on (note 60, period 100) -> done after 6 cycles (N=4); done_voice = 0, done_hit = 1, done_stole = 0; voice_en = 0001; period0 = 100.
2. Four note-ons (notes 60, 62, 64, 65), then note-on 67 -> voice 0 (age 3, oldest) stolen; done_stole = 1; voice_en = 1111; note0 = 67.
3. From the full state of test 2, note-off 64 -> done_voice = 2, done_hit = 1; voice_en = 1011; period2 = 0. Then note-on 70 -> fills voice 2 with done_stole = 0.
4. Note-off 99 with no match -> done_valid = 1, done_hit = 0; voice_en unchanged.
5. Hold req_valid high continuously -> req_ready low during SCAN/COMMIT; exactly one acceptance per 6 cycles; changing req_note mid-scan has no effect.
6. Assert rst_n low asynchronously mid-SCAN (between clock edges) -> voice_en = 0 immediately; no done pulse; req_ready = 1 after release. With AW = 2, ages saturate at 3 across repeated note-ons.
